// File: rtl/sha3_scan_job_driver_if.sv
// Bundle of host-job, scanner and result-readout signals for sha3_scan_job_driver.
// The master modport is the driver itself; the slave modport is the
// environment (host plus scanner) on the other side.
interface sha3_scan_job_driver_if #(
  parameter int JOB_ID_W = 4
);
  // host job handshake
  logic                  job_valid;
  logic                  job_ready;
  logic [23:0][31:0]     job_blobby;
  logic [63:0]           job_threshold;

  // scanner control and status
  logic                  scan_start;
  logic [23:0][31:0]     scan_blobby;
  logic [63:0]           scan_threshold;
  logic                  scan_dispatching;
  logic                  scan_evaluating;
  logic                  scan_found;
  logic [49:0][31:0]     scan_hash;
  logic [31:0]           scan_nonce;

  // result readout
  logic                  res_valid;
  logic                  res_ready;
  logic [31:0]           res_nonce;
  logic [63:0]           res_hash_head;
  logic [JOB_ID_W-1:0]   res_job_id;

  // job status
  logic                  job_done;
  logic                  ack_error;
  logic                  overflow;

  modport master (
    input  job_valid, job_blobby, job_threshold,
    input  scan_dispatching, scan_evaluating, scan_found, scan_hash, scan_nonce,
    input  res_ready,
    output job_ready, scan_start, scan_blobby, scan_threshold,
    output res_valid, res_nonce, res_hash_head, res_job_id,
    output job_done, ack_error, overflow
  );

  modport slave (
    output job_valid, job_blobby, job_threshold,
    output scan_dispatching, scan_evaluating, scan_found, scan_hash, scan_nonce,
    output res_ready,
    input  job_ready, scan_start, scan_blobby, scan_threshold,
    input  res_valid, res_nonce, res_hash_head, res_job_id,
    input  job_done, ack_error, overflow
  );
endinterface

// File: rtl/sha3_scan_job_driver.sv
// Job initiator / result collector for the sha3 scanner.
// Accepts one job at a time from the host, pulses the scanner start, waits
// for the scanner to acknowledge and finish, and buffers every found
// nonce / hash-head pair in a small FIFO that the host drains independently.
module sha3_scan_job_driver #(
  parameter int RESULT_DEPTH = 8,
  parameter int JOB_ID_W     = 4,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  sha3_scan_job_driver_if.master        bus
);

  localparam int PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [ACK_W-1:0]    ACK_LOAD  = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(RESULT_DEPTH);
  localparam logic [JOB_ID_W-1:0] ID_ONE    = JOB_ID_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    WAIT_ACK = 3'd2,
    SCAN     = 3'd3,
    DONE     = 3'd4
  } state_t;

  // FSM
  state_t               state_r;
  state_t               state_next_s;
  logic [ACK_W-1:0]     ack_cnt_r;
  logic [ACK_W-1:0]     ack_cnt_next_s;
  logic                 accept_s;
  logic                 ack_fail_s;
  logic                 status_busy_s;

  // registered outputs and job context
  logic                 job_ready_r;
  logic                 scan_start_r;
  logic                 job_done_r;
  logic                 ack_error_r;
  logic                 overflow_r;
  logic [23:0][31:0]    blobby_r;
  logic [63:0]          threshold_r;
  logic [JOB_ID_W-1:0]  job_id_r;

  // result FIFO
  logic [31:0]          nonce_mem_r [RESULT_DEPTH];
  logic [63:0]          head_mem_r  [RESULT_DEPTH];
  logic [JOB_ID_W-1:0]  id_mem_r    [RESULT_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     count_next_s;
  logic                 res_valid_r;
  logic                 capture_window_s;
  logic                 push_req_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 drop_s;

  assign accept_s      = bus.job_valid && job_ready_r;
  assign status_busy_s = bus.scan_dispatching || bus.scan_evaluating;

  // Next-state logic: start pulse, acknowledge timeout, completion detection.
  always_comb begin
    state_next_s   = state_r;
    ack_cnt_next_s = ack_cnt_r;
    ack_fail_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        ack_cnt_next_s = ACK_LOAD;
        state_next_s   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (status_busy_s) begin
          state_next_s = SCAN;
        end else if (ack_cnt_r == {ACK_W{1'b0}}) begin
          ack_fail_s   = 1'b1;
          state_next_s = DONE;
        end else begin
          ack_cnt_next_s = ack_cnt_r - ACK_W'(1);
          state_next_s   = WAIT_ACK;
        end
      end
      SCAN: begin
        if (!status_busy_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SCAN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register; handshake outputs are decoded from the next state so they are flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ack_cnt_r    <= {ACK_W{1'b0}};
      job_ready_r  <= 1'b1;
      scan_start_r <= 1'b0;
      job_done_r   <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      ack_cnt_r    <= ack_cnt_next_s;
      job_ready_r  <= (state_next_s == IDLE);
      scan_start_r <= (state_next_s == START);
      job_done_r   <= (state_next_s == DONE);
    end
  end

  // Job context: latched only on acceptance so the scanner sees stable inputs all job long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blobby_r    <= '{default: 32'h0000_0000};
      threshold_r <= 64'h0000_0000_0000_0000;
      job_id_r    <= {JOB_ID_W{1'b0}};
      ack_error_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (accept_s) begin
      blobby_r    <= bus.job_blobby;
      threshold_r <= bus.job_threshold;
      job_id_r    <= job_id_r + ID_ONE;
      ack_error_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (ack_fail_s) begin
        ack_error_r <= 1'b1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO control: results are only meaningful once the scanner has been started.
  always_comb begin
    capture_window_s = 1'b0;
    case (state_r)
      WAIT_ACK: capture_window_s = 1'b1;
      SCAN:     capture_window_s = 1'b1;
      DONE:     capture_window_s = 1'b1;
      default:  capture_window_s = 1'b0;
    endcase
    push_req_s = bus.scan_found && capture_window_s;
    pop_s      = (count_r != {CNT_W{1'b0}}) && bus.res_ready;
    full_s     = (count_r == DEPTH_CNT);
    // a full FIFO still accepts a push when the head leaves in the same cycle
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO pointers and occupancy; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      res_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r     <= count_next_s;
      res_valid_r <= (count_next_s != {CNT_W{1'b0}});
    end
  end

  // FIFO storage; contents behind the pointers are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      nonce_mem_r[wr_ptr_r] <= bus.scan_nonce;
      head_mem_r[wr_ptr_r]  <= {bus.scan_hash[0], bus.scan_hash[1]};
      id_mem_r[wr_ptr_r]    <= job_id_r;
    end
  end

  assign bus.job_ready      = job_ready_r;
  assign bus.scan_start     = scan_start_r;
  assign bus.scan_blobby    = blobby_r;
  assign bus.scan_threshold = threshold_r;
  assign bus.job_done       = job_done_r;
  assign bus.ack_error      = ack_error_r;
  assign bus.overflow       = overflow_r;
  assign bus.res_valid      = res_valid_r;
  assign bus.res_nonce      = nonce_mem_r[rd_ptr_r];
  assign bus.res_hash_head  = head_mem_r[rd_ptr_r];
  assign bus.res_job_id     = id_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_sha3_scan_job_driver.sv
// Scoreboard bench for sha3_scan_job_driver: the stimulus process pushes the
// result each scanner "found" should produce; a monitor pops and compares at
// every host handshake on the result port.
module tb_sha3_scan_job_driver;

  typedef struct packed {
    logic [31:0] nonce;
    logic [63:0] head;
    logic [3:0]  id;
  } res_t;

  logic clk;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  res_t exp_q[$];
  logic [23:0][31:0] exp_blobby;

  sha3_scan_job_driver_if #(.JOB_ID_W(4)) bus ();

  sha3_scan_job_driver #(
    .RESULT_DEPTH (8),
    .JOB_ID_W     (4),
    .ACK_TIMEOUT  (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] hash_word(input logic [31:0] n, input int i);
    return n ^ {8'(i), 24'h5A_5A5A};
  endfunction

  task automatic drive_found(input logic on, input logic [31:0] n, input logic keep, input logic [3:0] id);
    res_t e;
    bus.scan_found = on;
    bus.scan_nonce = n;
    for (int i = 0; i < 50; i++) bus.scan_hash[i] = hash_word(n, i);
    if (on && keep) begin
      e.nonce = n;
      e.head  = {hash_word(n, 0), hash_word(n, 1)};
      e.id    = id;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_job(input logic [7:0] seed, input logic [63:0] thr);
    for (int i = 0; i < 24; i++) exp_blobby[i] = {seed, 8'(i), 16'hBEEF};
    bus.job_blobby    = exp_blobby;
    bus.job_threshold = thr;
    bus.job_valid     = 1'b1;
    tick();
    bus.job_valid     = 1'b0;
    bus.job_blobby    = ~exp_blobby;
    bus.job_threshold = ~thr;
    check("accept_job_ready", 64'(bus.job_ready), 64'd0);
    check("accept_scan_start", 64'(bus.scan_start), 64'd1);
    check("accept_blobby", 64'(bus.scan_blobby == exp_blobby), 64'd1);
    check("accept_threshold", bus.scan_threshold, thr);
  endtask

  // Monitor: every host pop is compared against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL res_extra: got nonce %h expected no result", bus.res_nonce);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("res_nonce", 64'(bus.res_nonce), 64'(e.nonce));
        check("res_hash_head", bus.res_hash_head, e.head);
        check("res_job_id", 64'(bus.res_job_id), 64'(e.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts, dones, done_at, ready_at, err_at, blob_bad;
    rst = 1'b1;
    bus.job_valid = 1'b0;
    bus.job_blobby = '0;
    bus.job_threshold = 64'd0;
    bus.scan_dispatching = 1'b0;
    bus.scan_evaluating = 1'b0;
    bus.res_ready = 1'b0;
    drive_found(1'b0, 32'd0, 1'b0, 4'd0);
    tick();
    tick();
    check("rst_job_ready", 64'(bus.job_ready), 64'd1);
    check("rst_scan_start", 64'(bus.scan_start), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_flags", 64'({bus.job_done, bus.ack_error, bus.overflow}), 64'd0);
    check("rst_scan_regs", 64'(bus.scan_blobby == '0 && bus.scan_threshold == 64'd0), 64'd1);
    rst = 1'b0;
    tick();

    // basic job with three results read back as they arrive
    bus.res_ready = 1'b1;
    start_job(8'h01, 64'h0000_FFFF_FFFF_FFFF);
    starts = 0; dones = 0; done_at = 0; ready_at = 0; blob_bad = 0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      bus.scan_dispatching = (c >= 3 && c <= 12);
      bus.scan_evaluating  = (c >= 13 && c <= 17);
      drive_found(c >= 5 && c <= 7, 32'(c), 1'b1, 4'd1);
      if (bus.scan_start) starts++;
      if (bus.job_done) begin dones++; done_at = c; end
      if (bus.job_ready && ready_at == 0) ready_at = c;
      if (bus.scan_blobby != exp_blobby || bus.scan_threshold != 64'h0000_FFFF_FFFF_FFFF) blob_bad++;
      if (c == 5) check("res_valid_before_push", 64'(bus.res_valid), 64'd0);
      if (c == 6) check("res_valid_after_push", 64'(bus.res_valid), 64'd1);
    end
    check("basic_extra_start", 64'(starts), 64'd0);
    check("basic_done_count", 64'(dones), 64'd1);
    check("basic_done_cycle", 64'(done_at), 64'd19);
    check("basic_ready_cycle", 64'(ready_at), 64'd20);
    check("basic_scan_stable", 64'(blob_bad), 64'd0);
    check("basic_drained", 64'(exp_q.size()), 64'd0);

    // overflow: ten founds with nobody reading
    bus.res_ready = 1'b0;
    start_job(8'h02, 64'h0000_0000_1234_5678);
    done_at = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      bus.scan_dispatching = (c <= 12);
      bus.scan_evaluating  = 1'b0;
      drive_found(c >= 2 && c <= 11, 32'(100 + c), c <= 9, 4'd2);
      if (bus.job_done) done_at = c;
      if (c == 10) check("overflow_not_yet", 64'(bus.overflow), 64'd0);
      if (c == 11) check("overflow_set", 64'(bus.overflow), 64'd1);
    end
    check("overflow_done_cycle", 64'(done_at), 64'd14);
    check("overflow_sticky", 64'(bus.overflow), 64'd1);

    // full FIFO: push and pop together, acceptance clears overflow
    start_job(8'h03, 64'hFFFF_0000_0000_0001);
    check("overflow_cleared", 64'(bus.overflow), 64'd0);
    check("full_res_valid", 64'(bus.res_valid), 64'd1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      bus.scan_dispatching = (c <= 5);
      drive_found(c == 3, 32'h0000_0300, 1'b1, 4'd3);
      bus.res_ready = (c == 3);
      if (c == 4) check("full_pushpop_no_overflow", 64'(bus.overflow), 64'd0);
    end
    bus.res_ready = 1'b1;
    for (int d = 1; d <= 8; d++) begin
      if (d == 8) check("full_pushpop_eighth", 64'(bus.res_valid), 64'd1);
      tick();
    end
    check("full_pushpop_empty", 64'(bus.res_valid), 64'd0);
    check("full_pushpop_drained", 64'(exp_q.size()), 64'd0);

    // acknowledge timeout
    start_job(8'h04, 64'h0000_0000_0000_00FF);
    dones = 0; done_at = 0; ready_at = 0; err_at = 0;
    bus.scan_dispatching = 1'b0;
    bus.scan_evaluating  = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      tick();
      if (bus.job_done) begin dones++; done_at = c; end
      if (bus.ack_error && err_at == 0) err_at = c;
      if (bus.job_ready && ready_at == 0) ready_at = c;
    end
    check("timeout_done_count", 64'(dones), 64'd1);
    check("timeout_done_cycle", 64'(done_at), 64'd65);
    check("timeout_err_cycle", 64'(err_at), 64'd65);
    check("timeout_ready_cycle", 64'(ready_at), 64'd66);
    check("timeout_err_sticky", 64'(bus.ack_error), 64'd1);

    // async reset mid-SCAN with three buffered results
    bus.res_ready = 1'b0;
    start_job(8'h05, 64'h0000_0000_0000_0F0F);
    check("ack_error_cleared", 64'(bus.ack_error), 64'd0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.scan_dispatching = 1'b1;
      drive_found(c >= 2 && c <= 4, 32'h0000_0500 + 32'(c), 1'b1, 4'd5);
    end
    check("pre_reset_res_valid", 64'(bus.res_valid), 64'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("async_rst_scan_start", 64'(bus.scan_start), 64'd0);
    check("async_rst_job_ready", 64'(bus.job_ready), 64'd1);
    bus.scan_dispatching = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // first job after reset is tagged 1 again
    bus.res_ready = 1'b1;
    start_job(8'h06, 64'h0000_0000_0000_0001);
    done_at = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.scan_dispatching = (c == 2);
      drive_found(c == 1, 32'h0000_0600, 1'b1, 4'd1);
      if (bus.job_done) done_at = c;
    end
    check("post_rst_done_cycle", 64'(done_at), 64'd4);
    check("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
